// File: rtl/servant_power_ctrl.sv
// rtl/servant_power_ctrl.sv - LF-domain sleep sequencer gating the HF clock
module servant_power_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int WAKE_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sleep_req,
  input  logic        i_wake,
  output logic        o_sleep_ack,
  output logic        o_clk_en,
  output logic        o_core_hold,
  output logic [1:0]  o_state,
  output logic [15:0] o_sleep_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_t;

  // Counter reload values; the counter expires on reaching zero, so the
  // number of cycles spent in a timed state equals the parameter.
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYCLES - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic        req_meta;
  logic        req_s;
  logic        wake_meta;
  logic        wake_s;

  state_t      state;
  logic [7:0]  cnt;
  logic        rearm;
  logic [15:0] sleep_cnt;
  logic        clk_en;
  logic        core_hold;
  logic        sleep_ack;

  // Two-flop synchronisers bring the core request and wake event into the LF domain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_meta  <= 1'b0;
      req_s     <= 1'b0;
      wake_meta <= 1'b0;
      wake_s    <= 1'b0;
    end else begin
      req_meta  <= i_sleep_req;
      req_s     <= req_meta;
      wake_meta <= i_wake;
      wake_s    <= wake_meta;
    end
  end

  // Sequencer FSM with registered outputs, shared drain/wake counter and sleep statistics
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // The HF clock comes straight back on; the core is in reset too, so
      // no stabilisation wait is needed.
      state     <= RUN;
      cnt       <= 8'd0;
      rearm     <= 1'b1;
      sleep_cnt <= 16'd0;
      clk_en    <= 1'b1;
      core_hold <= 1'b0;
      sleep_ack <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // A request must be seen low in RUN before another sleep is
          // accepted, so a request still held after wake cannot re-trigger.
          if (!req_s) begin
            rearm <= 1'b1;
          end
          if (req_s && rearm) begin
            state     <= DRAIN;
            cnt       <= DRAIN_LOAD;
            rearm     <= 1'b0;
            sleep_ack <= 1'b1;
          end
        end

        DRAIN: begin
          // Abort wins over counter expiry: a withdrawn request or a wake
          // seen during the drain must never gate the clock.
          if (!req_s || wake_s) begin
            state     <= RUN;
            sleep_ack <= 1'b0;
          end else if (cnt == 8'd0) begin
            // Hold rises on the same edge the clock is gated so the core is
            // never left running on a stopped clock.
            state     <= SLEEP;
            clk_en    <= 1'b0;
            core_hold <= 1'b1;
            if (sleep_cnt != CNT_MAX) begin
              sleep_cnt <= sleep_cnt + 16'd1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        SLEEP: begin
          if (wake_s) begin
            state  <= WAKE;
            cnt    <= WAKE_LOAD;
            clk_en <= 1'b1;
          end
        end

        WAKE: begin
          // Oscillator settling time; request and wake are deliberately
          // ignored until the core is released.
          if (cnt == 8'd0) begin
            state     <= RUN;
            core_hold <= 1'b0;
            sleep_ack <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign o_sleep_ack = sleep_ack;
  assign o_clk_en    = clk_en;
  assign o_core_hold = core_hold;
  assign o_state     = state;
  assign o_sleep_cnt = sleep_cnt;

endmodule

// File: tb/tb_servant_power_ctrl.sv
// tb/tb_servant_power_ctrl.sv - scoreboard bench for servant_power_ctrl
module tb_servant_power_ctrl;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_SLEEP = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sleep_req = 1'b0;
  logic        wake = 1'b0;
  logic        sleep_ack;
  logic        clk_en;
  logic        core_hold;
  logic [1:0]  state;
  logic [15:0] sleep_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] prev_state = 2'd0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [1:0]  st;
    logic        ce;
    logic        hold;
    logic        ack;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  servant_power_ctrl #(.DRAIN_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sleep_req (sleep_req),
    .i_wake      (wake),
    .o_sleep_ack (sleep_ack),
    .o_clk_en    (clk_en),
    .o_core_hold (core_hold),
    .o_state     (state),
    .o_sleep_cnt (sleep_cnt)
  );

  always #5 clk = ~clk;

  // cycle number = count of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // expected state transition, 'off' rising edges after the current negedge
  task automatic push(input int off, input logic [1:0] st, input logic ce,
                      input logic hold, input logic ack, input logic [15:0] cnt);
    exp_t x;
    x.cyc  = cyc + off;
    x.st   = st;
    x.ce   = ce;
    x.hold = hold;
    x.ack  = ack;
    x.cnt  = cnt;
    sb.push_back(x);
  endtask

  // every observed state change must match the next expected transition
  always @(negedge clk) begin
    if (mon_en && state !== prev_state) begin
      if (sb.size() == 0) begin
        check("unexpected_transition", {30'd0, state}, {30'd0, prev_state});
      end else begin
        e = sb.pop_front();
        check("tr_cycle", cyc, e.cyc);
        check("tr_state", {30'd0, state}, {30'd0, e.st});
        check("tr_clk_en", {31'd0, clk_en}, {31'd0, e.ce});
        check("tr_hold", {31'd0, core_hold}, {31'd0, e.hold});
        check("tr_ack", {31'd0, sleep_ack}, {31'd0, e.ack});
        check("tr_sleep_cnt", {16'd0, sleep_cnt}, {16'd0, e.cnt});
      end
    end
    prev_state <= state;
  end

  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_clk_en", {31'd0, clk_en}, 32'd1);
    check("rst_hold", {31'd0, core_hold}, 32'd0);
    check("rst_ack", {31'd0, sleep_ack}, 32'd0);
    check("rst_sleep_cnt", {16'd0, sleep_cnt}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // full sleep/wake cycle
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd0);
    push(7, S_SLEEP, 1'b0, 1'b1, 1'b1, 16'd1);
    sleep_req = 1'b1;
    tick(8);
    push(3, S_WAKE, 1'b1, 1'b1, 1'b1, 16'd1);
    push(5, S_RUN,  1'b1, 1'b0, 1'b0, 16'd1);
    wake = 1'b1;
    tick(6);
    wake = 1'b0;

    // request held through wake: no re-entry without rearm
    tick(12);
    check("no_rearm_state", {30'd0, state}, {30'd0, S_RUN});
    check("no_rearm_ack", {31'd0, sleep_ack}, 32'd0);

    // pulse low 3 cycles, then re-enter
    sleep_req = 1'b0;
    tick(3);
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd1);
    push(7, S_SLEEP, 1'b0, 1'b1, 1'b1, 16'd2);
    sleep_req = 1'b1;
    tick(8);
    push(3, S_WAKE, 1'b1, 1'b1, 1'b1, 16'd2);
    push(5, S_RUN,  1'b1, 1'b0, 1'b0, 16'd2);
    wake = 1'b1;
    tick(6);
    sleep_req = 1'b0;
    wake = 1'b0;
    tick(4);

    // abort by dropped request, seen on the same edge the counter expires
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd2);
    push(7, S_RUN,   1'b1, 1'b0, 1'b0, 16'd2);
    sleep_req = 1'b1;
    tick(4);
    sleep_req = 1'b0;
    tick(8);

    // abort by wake; request still high so no rearm
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd2);
    push(7, S_RUN,   1'b1, 1'b0, 1'b0, 16'd2);
    sleep_req = 1'b1;
    tick(4);
    wake = 1'b1;
    tick(10);
    check("wake_abort_run", {30'd0, state}, {30'd0, S_RUN});
    check("wake_abort_clk_en", {31'd0, clk_en}, 32'd1);
    sleep_req = 1'b0;
    wake = 1'b0;
    tick(4);

    // wake pre-asserted: DRAIN aborts on its first cycle
    wake = 1'b1;
    tick(3);
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd2);
    push(4, S_RUN,   1'b1, 1'b0, 1'b0, 16'd2);
    sleep_req = 1'b1;
    tick(10);
    sleep_req = 1'b0;
    wake = 1'b0;
    tick(4);

    // wake_s rises on the DRAIN->SLEEP edge: SLEEP lasts one cycle
    push(3,  S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd2);
    push(7,  S_SLEEP, 1'b0, 1'b1, 1'b1, 16'd3);
    push(8,  S_WAKE,  1'b1, 1'b1, 1'b1, 16'd3);
    push(10, S_RUN,   1'b1, 1'b0, 1'b0, 16'd3);
    sleep_req = 1'b1;
    tick(5);
    wake = 1'b1;
    tick(7);
    sleep_req = 1'b0;
    wake = 1'b0;
    tick(4);

    // reset while in SLEEP
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'd3);
    push(7, S_SLEEP, 1'b0, 1'b1, 1'b1, 16'd4);
    sleep_req = 1'b1;
    tick(8);
    push(1, S_RUN, 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b1;
    sleep_req = 1'b0;
    tick(1);
    check("midrst_clk_en", {31'd0, clk_en}, 32'd1);
    check("midrst_hold", {31'd0, core_hold}, 32'd0);
    check("midrst_ack", {31'd0, sleep_ack}, 32'd0);
    check("midrst_sleep_cnt", {16'd0, sleep_cnt}, 32'd0);
    rst = 1'b0;
    tick(4);

    // saturation of the sleep counter
    force dut.sleep_cnt = 16'hFFFF;
    tick(1);
    release dut.sleep_cnt;
    tick(1);
    push(3, S_DRAIN, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    push(7, S_SLEEP, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    sleep_req = 1'b1;
    tick(8);
    push(3, S_WAKE, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    push(5, S_RUN,  1'b1, 1'b0, 1'b0, 16'hFFFF);
    wake = 1'b1;
    tick(6);
    sleep_req = 1'b0;
    wake = 1'b0;
    tick(3);
    check("sat_sleep_cnt", {16'd0, sleep_cnt}, 32'hFFFF);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
